fcw_hop_sequencer: RTL

- Parametrised frequency-control-word (FCW) sequencer feeding the downstream NCO/phase accumulator of the frequency-synthesis chain.
- Generalises the fixed two-tone toggler in four ways:
  - programmable tone table of NUM_TONES entries;
  - programmable dwell time in prescaled ticks;
  - four modes: hold, toggle, sweep, ramp/chirp;
  - start/stop control and a hop strobe for downstream alignment.

---
 rtl/fcw_seq_pkg.sv | 20 ++
 rtl/fcw_hop_sequencer_prescaler.sv | 42 ++++
 rtl/fcw_hop_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fcw_seq_pkg.sv
// Shared types and reset constants for the FCW hop sequencer.
// Modes, FSM states and default tone table contents.
package fcw_seq_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_SWEEP  = 2'd2,
    MODE_RAMP   = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int TONE0_RST = 12;
  localparam int TONE1_RST = 94;

endpackage

// File: rtl/fcw_hop_sequencer_prescaler.sv
// tick_prescaler: divides clk by PRESCALE, one-cycle tick on wrap.
// Ports: clk, reset (async high), clr (sync clear), en, tick.
module tick_prescaler #(
  parameter int PRESCALE = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fcw_hop_sequencer.sv
// FCW hop sequencer: tone table + dwell timer driving the NCO word.
// Ports: cfg_* table write, mode/dwell/start/stop control, fcw/tone_idx/hop/running out.
module fcw_hop_sequencer #(
  parameter int FCW_W     = 12,
  parameter int NUM_TONES = 4,
  parameter int DWELL_W   = 16,
  parameter int PRESCALE  = 100,
  parameter int TONE0_RST = fcw_seq_pkg::TONE0_RST,
  parameter int TONE1_RST = fcw_seq_pkg::TONE1_RST
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_TONES)-1:0] cfg_addr,
  input  logic [FCW_W-1:0]             cfg_data,
  input  logic [1:0]                   mode,
  input  logic [DWELL_W-1:0]           dwell,
  input  logic                         start,
  input  logic                         stop,
  output logic [FCW_W-1:0]             fcw,
  output logic [$clog2(NUM_TONES)-1:0] tone_idx,
  output logic                         hop,
  output logic                         running
);

  import fcw_seq_pkg::*;

  localparam int IW = $clog2(NUM_TONES);

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DWELL_W-1:0]   dcnt_q, dcnt_d;
  logic [FCW_W-1:0]     fcw_q, fcw_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 hop_q, hop_d;
  logic [FCW_W-1:0]     table_q [NUM_TONES];
  logic [FCW_W-1:0]     table_d [NUM_TONES];

  logic                 pre_clr;
  logic                 pre_en;
  logic                 tick;
  logic [FCW_W:0]       ramp_sum;
  logic [IW-1:0]        nxt_idx;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_pre (
    .clk  (clk),
    .reset(reset),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (tick)
  );

  assign pre_en = (state_q == ST_RUN);

  // Table writes land one cycle later, so hops see the old entry.
  always_comb begin
    table_d = table_q;
    if (cfg_we) begin
      table_d[cfg_addr] = cfg_data;
    end
  end

  // Carry bit kept so an overflowing sum also wraps back to entry 0.
  assign ramp_sum = {1'b0, fcw_q} + {1'b0, table_q[2]};

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dwell_d = dwell_q;
    dcnt_d  = dcnt_q;
    fcw_d   = fcw_q;
    idx_d   = idx_q;
    hop_d   = 1'b0;
    pre_clr = 1'b0;
    nxt_idx = '0;
    if (stop) begin
      state_d = ST_IDLE;
      dcnt_d  = '0;
      pre_clr = 1'b1;
    end else if (start) begin
      state_d = ST_RUN;
      mode_d  = mode_e'(mode);
      dwell_d = (dwell == '0) ? DWELL_W'(1) : dwell;
      dcnt_d  = '0;
      pre_clr = 1'b1;
      fcw_d   = table_q[0];
      idx_d   = '0;
      hop_d   = 1'b1;
    end else if (state_q == ST_IDLE) begin
      dcnt_d  = '0;
      pre_clr = 1'b1;
    end else if (tick) begin
      if (dcnt_q == dwell_q - 1'b1) begin
        dcnt_d = '0;
        hop_d  = 1'b1;
        unique case (mode_q)
          MODE_HOLD: begin
            idx_d = '0;
            fcw_d = table_q[0];
          end
          MODE_TOGGLE: begin
            nxt_idx = (idx_q == '0) ? IW'(1) : '0;
            idx_d   = nxt_idx;
            fcw_d   = table_q[nxt_idx];
          end
          MODE_SWEEP: begin
            nxt_idx = idx_q + 1'b1;
            idx_d   = nxt_idx;
            fcw_d   = table_q[nxt_idx];
          end
          MODE_RAMP: begin
            idx_d = '0;
            if (ramp_sum > {1'b0, table_q[1]}) begin
              fcw_d = table_q[0];
            end else begin
              fcw_d = ramp_sum[FCW_W-1:0];
            end
          end
        endcase
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_HOLD;
      dwell_q <= DWELL_W'(1);
      dcnt_q  <= '0;
      fcw_q   <= '0;
      idx_q   <= '0;
      hop_q   <= 1'b0;
      for (int i = 0; i < NUM_TONES; i++) begin
        table_q[i] <= '0;
      end
      table_q[0] <= FCW_W'(TONE0_RST);
      table_q[1] <= FCW_W'(TONE1_RST);
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dwell_q <= dwell_d;
      dcnt_q  <= dcnt_d;
      fcw_q   <= fcw_d;
      idx_q   <= idx_d;
      hop_q   <= hop_d;
      table_q <= table_d;
    end
  end

  assign fcw      = fcw_q;
  assign tone_idx = idx_q;
  assign hop      = hop_q;
  assign running  = (state_q == ST_RUN);

endmodule
